// File: rtl/tama_pixel_source_if.sv
// Pixel stream bundle between the pattern source and the display controller.
// The source drives valid/data/coordinates; the sink answers with ready.
interface tama_pixel_source_if #(
    parameter int PIXEL_SIZE = 16,
    parameter int XW         = 8,
    parameter int YW         = 8
) ();
    logic                  pix_valid;
    logic                  pix_ready;
    logic [PIXEL_SIZE-1:0] pix_data;
    logic [XW-1:0]         pix_x;
    logic [YW-1:0]         pix_y;
    logic                  frame_start;

    modport master (
        output pix_valid, pix_data, pix_x, pix_y, frame_start,
        input  pix_ready
    );

    modport slave (
        input  pix_valid, pix_data, pix_x, pix_y, frame_start,
        output pix_ready
    );
endinterface

// File: rtl/tama_pixel_source.sv
// Frame pattern generator: streams one frame of H_RES x V_RES pixels over a
// valid/ready handshake in one of four patterns, single-shot or continuous.
module tama_pixel_source #(
    parameter int H_RES       = 176,
    parameter int V_RES       = 220,
    parameter int PIXEL_SIZE  = 16,
    parameter int BAR_COUNT   = 8,
    parameter int CHECK_SHIFT = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  continuous,
    input  logic [1:0]            mode,
    input  logic [PIXEL_SIZE-1:0] fg_color,
    input  logic [PIXEL_SIZE-1:0] bg_color,
    tama_pixel_source_if.master   pix,
    output logic                  frame_done,
    output logic                  busy
);
    localparam int XW    = $clog2(H_RES);
    localparam int YW    = $clog2(V_RES);
    localparam int BAR_W = H_RES / BAR_COUNT;

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;

    state_t                r_state, w_state_nx;
    logic [1:0]            r_mode;
    logic [PIXEL_SIZE-1:0] r_fg, r_bg;
    logic                  r_cont;
    logic [XW-1:0]         r_x, w_x_nx;
    logic [YW-1:0]         r_y, w_y_nx;
    logic [2:0]            r_bar, w_bar_nx;
    logic [XW-1:0]         r_bcnt, w_bcnt_nx;
    logic                  r_valid, w_valid_nx;
    logic [PIXEL_SIZE-1:0] r_data, w_data_nx;
    logic                  r_fstart, w_fstart_nx;
    logic                  r_done, w_done_nx;
    logic                  w_latch;

    function automatic logic [PIXEL_SIZE-1:0] f_palette(input logic [2:0] idx);
        logic [15:0] p;
        case (idx)
            3'd0:    p = 16'hFFFF;
            3'd1:    p = 16'hFFE0;
            3'd2:    p = 16'h07FF;
            3'd3:    p = 16'h07E0;
            3'd4:    p = 16'hF81F;
            3'd5:    p = 16'hF800;
            3'd6:    p = 16'h001F;
            default: p = 16'h0000;
        endcase
        return PIXEL_SIZE'(p);
    endfunction

    function automatic logic [PIXEL_SIZE-1:0] f_pattern(
        input logic [1:0]            m,
        input logic [PIXEL_SIZE-1:0] fg,
        input logic [PIXEL_SIZE-1:0] bg,
        input logic [XW-1:0]         x,
        input logic [YW-1:0]         y,
        input logic [2:0]            bar
    );
        logic xb, yb, edge_px;
        xb      = ((x >> CHECK_SHIFT) & XW'(1)) != '0;
        yb      = ((y >> CHECK_SHIFT) & YW'(1)) != '0;
        edge_px = (x == '0) || (x == XW'(H_RES - 1)) || (y == '0) || (y == YW'(V_RES - 1));
        case (m)
            2'd0:    return fg;
            2'd1:    return f_palette(bar);
            2'd2:    return (xb ^ yb) ? fg : bg;
            default: return edge_px ? fg : bg;
        endcase
    endfunction

    always_comb begin
        w_state_nx = r_state;
        w_x_nx     = r_x;
        w_y_nx     = r_y;
        w_bar_nx   = r_bar;
        w_bcnt_nx  = r_bcnt;
        w_valid_nx = r_valid;
        w_data_nx  = r_data;
        w_done_nx  = 1'b0;
        w_latch    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_latch    = 1'b1;
                    w_state_nx = S_STREAM;
                    w_x_nx     = '0;
                    w_y_nx     = '0;
                    w_bar_nx   = '0;
                    w_bcnt_nx  = '0;
                    w_valid_nx = 1'b1;
                    w_data_nx  = f_pattern(mode, fg_color, bg_color, '0, '0, '0);
                end
            end
            S_STREAM: begin
                if (r_valid && pix.pix_ready) begin
                    if (r_x == XW'(H_RES - 1)) begin
                        w_x_nx    = '0;
                        w_bar_nx  = '0;
                        w_bcnt_nx = '0;
                        if (r_y == YW'(V_RES - 1)) begin
                            w_state_nx = S_DONE;
                            w_y_nx     = '0;
                            w_valid_nx = 1'b0;
                            w_done_nx  = 1'b1;
                        end else begin
                            w_y_nx = r_y + 1'b1;
                        end
                    end else begin
                        w_x_nx = r_x + 1'b1;
                        // Last bar absorbs the remainder columns, so it never advances.
                        if (r_bar != 3'(BAR_COUNT - 1)) begin
                            if (r_bcnt == XW'(BAR_W - 1)) begin
                                w_bar_nx  = r_bar + 1'b1;
                                w_bcnt_nx = '0;
                            end else begin
                                w_bcnt_nx = r_bcnt + 1'b1;
                            end
                        end
                    end
                    if (w_valid_nx) begin
                        w_data_nx = f_pattern(r_mode, r_fg, r_bg, w_x_nx, w_y_nx, w_bar_nx);
                    end
                end
            end
            S_DONE: begin
                if (r_cont) begin
                    w_latch    = 1'b1;
                    w_state_nx = S_STREAM;
                    w_valid_nx = 1'b1;
                    w_data_nx  = f_pattern(mode, fg_color, bg_color, '0, '0, '0);
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
        w_fstart_nx = w_valid_nx && (w_x_nx == '0) && (w_y_nx == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_mode   <= '0;
            r_fg     <= '0;
            r_bg     <= '0;
            r_cont   <= 1'b0;
            r_x      <= '0;
            r_y      <= '0;
            r_bar    <= '0;
            r_bcnt   <= '0;
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_fstart <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_x      <= w_x_nx;
            r_y      <= w_y_nx;
            r_bar    <= w_bar_nx;
            r_bcnt   <= w_bcnt_nx;
            r_valid  <= w_valid_nx;
            r_data   <= w_data_nx;
            r_fstart <= w_fstart_nx;
            r_done   <= w_done_nx;
            if (w_latch) begin
                r_mode <= mode;
                r_fg   <= fg_color;
                r_bg   <= bg_color;
                r_cont <= continuous;
            end
        end
    end

    assign pix.pix_valid   = r_valid;
    assign pix.pix_data    = r_data;
    assign pix.pix_x       = r_x;
    assign pix.pix_y       = r_y;
    assign pix.frame_start = r_fstart;
    assign frame_done      = r_done;
    assign busy            = (r_state != S_IDLE);
endmodule

// File: tb/tb_tama_pixel_source.sv
// Self-checking bench for tama_pixel_source on an 8x4 frame with 4 bars and
// 2-pixel checker tiles; expected pixels come from a plain arithmetic model.
module tb_tama_pixel_source;
    localparam int H    = 8;
    localparam int V    = 4;
    localparam int BC   = 4;
    localparam int CS   = 1;
    localparam int PS   = 16;
    localparam int XW   = $clog2(H);
    localparam int YW   = $clog2(V);
    localparam int NPIX = H * V;

    logic          clk = 1'b0;
    logic          rst;
    logic          start = 1'b0;
    logic          continuous = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [15:0]   fg_color = '0;
    logic [15:0]   bg_color = '0;
    logic          frame_done;
    logic          busy;

    tama_pixel_source_if #(.PIXEL_SIZE(PS), .XW(XW), .YW(YW)) pix ();

    tama_pixel_source #(
        .H_RES(H), .V_RES(V), .PIXEL_SIZE(PS), .BAR_COUNT(BC), .CHECK_SHIFT(CS)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .continuous(continuous), .mode(mode),
        .fg_color(fg_color), .bg_color(bg_color), .pix(pix),
        .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int done_mon = 0;

    always @(negedge clk) if (frame_done === 1'b1) done_mon++;

    logic [15:0] c_data[$];
    int          c_x[$];
    int          c_y[$];
    logic        c_fs[$];
    int          c_cyc[$];
    int          c_done_cyc[$];
    int          stab_err;
    bit          timed_out;

    function automatic logic [15:0] model_pix(input int m, input logic [15:0] fg,
                                              input logic [15:0] bg, input int x, input int y);
        logic [15:0] r;
        int b;
        case (m)
            0: r = fg;
            1: begin
                b = x / (H / BC);
                if (b > BC - 1) b = BC - 1;
                case (b)
                    0: r = 16'hFFFF;
                    1: r = 16'hFFE0;
                    2: r = 16'h07FF;
                    3: r = 16'h07E0;
                    4: r = 16'hF81F;
                    5: r = 16'hF800;
                    6: r = 16'h001F;
                    default: r = 16'h0000;
                endcase
            end
            2: r = ((((x >> CS) ^ (y >> CS)) & 1) != 0) ? fg : bg;
            default: r = (x == 0 || x == H - 1 || y == 0 || y == V - 1) ? fg : bg;
        endcase
        return r;
    endfunction

    task automatic start_frame(input logic [1:0] m, input logic [15:0] fg,
                               input logic [15:0] bg, input logic cont);
        @(posedge clk); #1;
        mode = m; fg_color = fg; bg_color = bg; continuous = cont; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Records every transfer and frame_done until nframes done pulses are seen.
    task automatic capture(input int nframes, input bit rnd_ready, input bit start_in_done,
                           input logic [15:0] alt_fg, input int max_cyc);
        logic [15:0] s_data;
        int s_x, s_y;
        bit stall;
        stall = 0; s_data = '0; s_x = 0; s_y = 0;
        c_data.delete(); c_x.delete(); c_y.delete(); c_fs.delete();
        c_cyc.delete(); c_done_cyc.delete();
        stab_err = 0; timed_out = 1;
        for (int cyc = 0; cyc < max_cyc; cyc++) begin
            if (stall && (pix.pix_valid !== 1'b1 || pix.pix_data !== s_data ||
                          int'(pix.pix_x) != s_x || int'(pix.pix_y) != s_y)) stab_err++;
            stall = 0;
            if (frame_done === 1'b1) begin
                c_done_cyc.push_back(cyc);
                if (c_done_cyc.size() == 1 && nframes > 1) begin
                    fg_color = alt_fg;
                    continuous = 1'b0;
                end
                if (start_in_done) start = 1'b1;
                if (c_done_cyc.size() == nframes) begin
                    timed_out = 0;
                    break;
                end
            end
            pix.pix_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (pix.pix_valid === 1'b1) begin
                if (pix.pix_ready) begin
                    c_data.push_back(pix.pix_data);
                    c_x.push_back(int'(pix.pix_x));
                    c_y.push_back(int'(pix.pix_y));
                    c_fs.push_back(pix.frame_start);
                    c_cyc.push_back(cyc);
                end else begin
                    stall = 1; s_data = pix.pix_data;
                    s_x = int'(pix.pix_x); s_y = int'(pix.pix_y);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pix.pix_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({pix.pix_valid, pix.pix_data, pix.pix_x, pix.pix_y, pix.frame_start, frame_done, busy} !== '0) begin
            bad++;
            $display("FAIL reset_state: got valid=%b data=%h x=%0d y=%0d fs=%b done=%b busy=%b, want all 0",
                     pix.pix_valid, pix.pix_data, pix.pix_x, pix.pix_y, pix.frame_start, frame_done, busy);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b0 || pix.pix_valid !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset: got busy=%b valid=%b, want 0 0", busy, pix.pix_valid);
        end
    endtask

    task automatic test_solid();
        int p;
        logic [15:0] bg, e;
        bg = 16'($urandom);
        start_frame(2'd0, 16'hF800, bg, 1'b0);
        capture(1, 0, 1, '0, 200);
        @(posedge clk); #1;
        start = 1'b0;
        total++;
        if (timed_out || c_data.size() != NPIX || c_done_cyc.size() != 1) begin
            bad++;
            $display("FAIL solid_count: got transfers=%0d dones=%0d timeout=%0d, want %0d 1 0",
                     c_data.size(), c_done_cyc.size(), timed_out, NPIX);
        end
        for (int i = 0; i < c_data.size(); i++) begin
            p = i % NPIX; e = model_pix(0, 16'hF800, bg, p % H, p / H);
            total++;
            if (c_data[i] !== e || c_x[i] != p % H || c_y[i] != p / H || c_fs[i] !== (p == 0)) begin
                bad++;
                $display("FAIL solid_pix[%0d]: got data=%h x=%0d y=%0d fs=%b, want data=%h x=%0d y=%0d fs=%b",
                         i, c_data[i], c_x[i], c_y[i], c_fs[i], e, p % H, p / H, p == 0);
            end
        end
        if (c_data.size() == NPIX && c_done_cyc.size() == 1) begin
            total++;
            if (c_done_cyc[0] - c_cyc[NPIX-1] != 1) begin
                bad++;
                $display("FAIL solid_done_gap: got %0d cycles after last transfer, want 1",
                         c_done_cyc[0] - c_cyc[NPIX-1]);
            end
        end
        total++;
        if (busy !== 1'b0 || pix.pix_valid !== 1'b0) begin
            bad++;
            $display("FAIL solid_idle_after_done: got busy=%b valid=%b, want 0 0", busy, pix.pix_valid);
        end
    endtask

    task automatic test_pattern(input logic [1:0] m, input logic [15:0] fg, input logic [15:0] bg,
                                input bit rnd_ready);
        int p;
        logic [15:0] e;
        start_frame(m, fg, bg, 1'b0);
        mode = ~m; fg_color = ~fg; bg_color = ~bg;
        capture(1, rnd_ready, 0, '0, 400);
        total++;
        if (timed_out || c_data.size() != NPIX || stab_err != 0) begin
            bad++;
            $display("FAIL mode%0d_frame: got transfers=%0d unstable=%0d timeout=%0d, want %0d 0 0",
                     m, c_data.size(), stab_err, timed_out, NPIX);
        end
        for (int i = 0; i < c_data.size(); i++) begin
            p = i % NPIX; e = model_pix(int'(m), fg, bg, p % H, p / H);
            total++;
            if (c_data[i] !== e || c_x[i] != p % H || c_y[i] != p / H || c_fs[i] !== (p == 0)) begin
                bad++;
                $display("FAIL mode%0d_pix[%0d]: got data=%h x=%0d y=%0d fs=%b, want data=%h x=%0d y=%0d fs=%b",
                         m, i, c_data[i], c_x[i], c_y[i], c_fs[i], e, p % H, p / H, p == 0);
            end
        end
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL mode%0d_busy_end: got busy=%b, want 0", m, busy);
        end
    endtask

    task automatic test_continuous();
        int p;
        logic [15:0] e;
        start_frame(2'd0, 16'h001F, 16'h1234, 1'b1);
        capture(2, 0, 0, 16'h07E0, 400);
        total++;
        if (timed_out || c_data.size() != 2 * NPIX) begin
            bad++;
            $display("FAIL cont_count: got transfers=%0d timeout=%0d, want %0d 0",
                     c_data.size(), timed_out, 2 * NPIX);
        end
        for (int i = 0; i < c_data.size(); i++) begin
            p = i % NPIX;
            e = model_pix(0, (i < NPIX) ? 16'h001F : 16'h07E0, 16'h1234, p % H, p / H);
            total++;
            if (c_data[i] !== e || c_x[i] != p % H || c_y[i] != p / H || c_fs[i] !== (p == 0)) begin
                bad++;
                $display("FAIL cont_pix[%0d]: got data=%h x=%0d y=%0d fs=%b, want data=%h x=%0d y=%0d fs=%b",
                         i, c_data[i], c_x[i], c_y[i], c_fs[i], e, p % H, p / H, p == 0);
            end
        end
        if (c_data.size() == 2 * NPIX && c_done_cyc.size() == 2) begin
            total++;
            if (c_cyc[NPIX] - c_done_cyc[0] != 1) begin
                bad++;
                $display("FAIL cont_restart_gap: got %0d cycles from done to next pixel, want 1",
                         c_cyc[NPIX] - c_done_cyc[0]);
            end
        end
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL cont_stop: got busy=%b after second frame, want 0", busy);
        end
    endtask

    task automatic test_reset_mid_frame();
        int d0;
        logic [15:0] fg;
        fg = 16'($urandom);
        start_frame(2'd0, fg, 16'h0000, 1'b0);
        for (int n = 0; n < 13; n++) begin
            pix.pix_ready = 1'b1;
            @(posedge clk); #1;
        end
        total++;
        if (pix.pix_valid !== 1'b1 || int'(pix.pix_x) != 13 % H || int'(pix.pix_y) != 13 / H) begin
            bad++;
            $display("FAIL pre_reset_pos: got valid=%b x=%0d y=%0d, want 1 %0d %0d",
                     pix.pix_valid, pix.pix_x, pix.pix_y, 13 % H, 13 / H);
        end
        d0 = done_mon;
        #2 rst = 1'b1;
        #1;
        total++;
        if ({pix.pix_valid, pix.pix_data, pix.pix_x, pix.pix_y, pix.frame_start, frame_done, busy} !== '0) begin
            bad++;
            $display("FAIL async_reset: got valid=%b data=%h x=%0d y=%0d fs=%b done=%b busy=%b, want all 0",
                     pix.pix_valid, pix.pix_data, pix.pix_x, pix.pix_y, pix.frame_start, frame_done, busy);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if (done_mon != d0) begin
            bad++;
            $display("FAIL reset_no_done: got %0d frame_done pulses, want 0", done_mon - d0);
        end
        start_frame(2'd0, fg, 16'h0000, 1'b0);
        capture(1, 0, 0, '0, 200);
        total++;
        if (timed_out || c_data.size() != NPIX || c_x[0] != 0 || c_y[0] != 0 || c_fs[0] !== 1'b1 ||
            c_data[0] !== fg) begin
            bad++;
            $display("FAIL restart_frame: got transfers=%0d first x=%0d y=%0d fs=%b data=%h, want %0d 0 0 1 %h",
                     c_data.size(), (c_x.size() > 0) ? c_x[0] : -1, (c_y.size() > 0) ? c_y[0] : -1,
                     (c_fs.size() > 0) ? c_fs[0] : 1'bx, (c_data.size() > 0) ? c_data[0] : 16'hxxxx,
                     NPIX, fg);
        end
    endtask

    initial begin
        test_reset();
        test_solid();
        test_pattern(2'd1, 16'($urandom), 16'($urandom), 1'b0);
        test_pattern(2'd2, 16'hFFFF, 16'h0000, 1'b0);
        test_pattern(2'd3, 16'($urandom), 16'($urandom), 1'b1);
        test_continuous();
        test_reset_mid_frame();
        for (int k = 0; k < 4; k++) begin
            test_pattern(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom), 1'b1);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
